// File: rtl/mem_arbiter_ctrl.sv
// Shares the byte-wide RAM port between the instruction fetcher and the load/store buffer.
// Serialises 1/2/4-byte transfers into byte cycles and assembles read data little-endian.
module mem_arbiter_ctrl #(
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] IO_HI_BITS = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback_sign_from_rob,
  input  logic              fch_req,
  input  logic [ADDR_W-1:0] fch_addr,
  output logic              fch_done,
  output logic [31:0]       fch_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q, mem_a_q;
  logic [31:0]       wdata_q, buf_q, buf_d, fch_data_q, ls_rdata_q;
  logic [2:0]        nbytes_q, ocnt_q;
  logic              rvld_q, fch_done_q, ls_done_q, mem_wr_q;
  logic [7:0]        mem_dout_q;
  logic              io_stall, rd_last, is_read;
  logic [1:0]        ridx;

  function automatic logic [2:0] nsz(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] wbyte(input logic [31:0] w, input logic [2:0] i);
    case (i[1:0])
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // ocnt_q indexes the byte on mem_a; rvld_q marks that byte ocnt_q-1 is on mem_din now
  assign is_read  = (state_q == FETCH) || (state_q == LOAD);
  assign ridx     = ocnt_q[1:0] - 2'd1;
  assign rd_last  = rvld_q && (ocnt_q == nbytes_q);
  assign io_stall = (state_q == STORE) && (mem_a_q[17:16] == IO_HI_BITS) && io_buffer_full;

  always_comb begin
    buf_d = buf_q;
    if (rvld_q) begin
      case (ridx)
        2'd0:    buf_d[7:0]   = mem_din;
        2'd1:    buf_d[15:8]  = mem_din;
        2'd2:    buf_d[23:16] = mem_din;
        default: buf_d[31:24] = mem_din;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mem_a_q    <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      fch_data_q <= '0;
      ls_rdata_q <= '0;
      nbytes_q   <= '0;
      ocnt_q     <= '0;
      rvld_q     <= 1'b0;
      fch_done_q <= 1'b0;
      ls_done_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
    end else if (rdy) begin
      fch_done_q <= 1'b0;
      ls_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rollback_sign_from_rob && !fch_done_q && !ls_done_q) begin
            if (ls_req) begin
              addr_q   <= ls_addr;
              mem_a_q  <= ls_addr;
              wdata_q  <= ls_wdata;
              nbytes_q <= nsz(ls_size);
              ocnt_q   <= '0;
              rvld_q   <= 1'b0;
              buf_q    <= '0;
              if (ls_wr) begin
                state_q    <= STORE;
                mem_wr_q   <= 1'b1;
                mem_dout_q <= ls_wdata[7:0];
              end else begin
                state_q <= LOAD;
              end
            end else if (fch_req) begin
              state_q  <= FETCH;
              addr_q   <= fch_addr;
              mem_a_q  <= fch_addr;
              nbytes_q <= 3'd4;
              ocnt_q   <= '0;
              rvld_q   <= 1'b0;
              buf_q    <= '0;
            end
          end
        end
        FETCH, LOAD: begin
          if (rollback_sign_from_rob) begin
            state_q <= IDLE;
            mem_a_q <= '0;
            rvld_q  <= 1'b0;
          end else begin
            buf_q <= buf_d;
            if (rd_last) begin
              state_q <= IDLE;
              rvld_q  <= 1'b0;
              if (state_q == FETCH) begin
                fch_done_q <= 1'b1;
                fch_data_q <= buf_d;
              end else begin
                ls_done_q  <= 1'b1;
                ls_rdata_q <= buf_d;
              end
            end else if (ocnt_q < nbytes_q) begin
              ocnt_q  <= ocnt_q + 3'd1;
              rvld_q  <= 1'b1;
              mem_a_q <= (ocnt_q + 3'd1 < nbytes_q) ? addr_q + ADDR_W'(ocnt_q + 3'd1) : '0;
            end else begin
              rvld_q <= 1'b0;
            end
          end
        end
        STORE: begin
          if (!io_stall) begin
            if (ocnt_q == nbytes_q - 3'd1) begin
              state_q    <= IDLE;
              ls_done_q  <= 1'b1;
              mem_wr_q   <= 1'b0;
              mem_a_q    <= '0;
              mem_dout_q <= '0;
            end else begin
              ocnt_q     <= ocnt_q + 3'd1;
              mem_a_q    <= addr_q + ADDR_W'(ocnt_q + 3'd1);
              mem_dout_q <= wbyte(wdata_q, ocnt_q + 3'd1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end else if (is_read && rvld_q) begin
      // RAM keeps reading while frozen, so step back and re-read the byte that was in flight
      ocnt_q  <= ocnt_q - 3'd1;
      mem_a_q <= addr_q + ADDR_W'(ocnt_q - 3'd1);
      rvld_q  <= 1'b0;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q && rdy && !io_stall;
  assign fch_done = fch_done_q;
  assign fch_data = fch_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl with a byte RAM model (fixed ROM pattern plus written bytes).
module tb_mem_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        rollback_sign_from_rob = 1'b0;
  logic        fch_req = 1'b0;
  logic [31:0] fch_addr = '0;
  logic        fch_done;
  logic [31:0] fch_data;
  logic        ls_req = 1'b0;
  logic        ls_wr = 1'b0;
  logic [1:0]  ls_size = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  mem_arbiter_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_sign_from_rob(rollback_sign_from_rob),
    .fch_req(fch_req), .fch_addr(fch_addr), .fch_done(fch_done), .fch_data(fch_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h00;
      32'h102: return 8'h00;
      32'h103: return 8'h93;
      default: return a[7:0] + 8'h11;
    endcase
  endfunction

  bit [7:0] wm [0:1023];
  bit       wv [0:1023];

  always @(posedge clk) begin
    if (mem_wr) begin
      wm[mem_a[9:0]] <= mem_dout;
      wv[mem_a[9:0]] <= 1'b1;
      wr_cnt <= wr_cnt + 1;
    end
    mem_din <= wv[mem_a[9:0]] ? wm[mem_a[9:0]] : rom(mem_a);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a load from idle and returns data plus the cycle of ls_done (0 if it never came)
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz,
                         output logic [31:0] d, output int cyc);
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = sz; ls_addr = a;
    cyc = 0; d = '0;
    for (int c = 1; c <= 30 && cyc == 0; c++) begin
      tick();
      if (ls_done) begin cyc = c; d = ls_rdata; ls_req = 1'b0; end
    end
    ls_req = 1'b0;
    tick();
  endtask

  initial begin
    int lc, fc, w0, any;
    logic [31:0] d;

    tick(); tick();
    rst = 1'b0;
    chk("reset mem_a", mem_a, 32'h0);
    chk("reset mem_wr", {31'b0, mem_wr}, 32'h0);
    chk("reset dones", {30'b0, fch_done, ls_done}, 32'h0);
    chk("reset data", fch_data | ls_rdata, 32'h0);

    // fetch 0x100
    fch_req = 1'b1; fch_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("fetch mem_a c%0d", i + 1), mem_a, 32'h100 + 32'(i));
    end
    tick();
    chk("fetch no early done", {31'b0, fch_done}, 32'h0);
    tick();
    chk("fetch done c6", {31'b0, fch_done}, 32'h1);
    chk("fetch data", fch_data, 32'h93000013);
    fch_req = 1'b0;
    tick();
    chk("fetch done one cycle", {31'b0, fch_done}, 32'h0);
    chk("idle mem_a", mem_a, 32'h0);

    // simultaneous load word 0x200 and fetch 0x180
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h200;
    fch_req = 1'b1; fch_addr = 32'h180;
    lc = 0; fc = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (ls_done && lc == 0) begin lc = c; ls_req = 1'b0; chk("arb load data", ls_rdata, 32'h14131211); end
      if (fch_done && fc == 0) begin fc = c; fch_req = 1'b0; chk("arb fetch data", fch_data, 32'h94939291); end
    end
    chk("arb ls_done cycle", 32'(lc), 32'd6);
    chk("arb fch_done cycle", 32'(fc), 32'd13);

    // store half 0xBEEF at 0x304
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h304; ls_wdata = 32'h0000BEEF;
    tick();
    chk("sh c1", {mem_wr, 15'b0, mem_a[7:0], mem_dout}, {1'b1, 15'b0, 8'h04, 8'hEF});
    tick();
    chk("sh c2", {mem_wr, 15'b0, mem_a[7:0], mem_dout}, {1'b1, 15'b0, 8'h05, 8'hBE});
    tick();
    chk("sh done c3", {30'b0, ls_done, mem_wr}, 32'h2);
    ls_req = 1'b0;
    tick();

    // IO store with buffer full for three cycles
    io_buffer_full = 1'b1; w0 = wr_cnt;
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h000000A5;
    any = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_wr) any = 1;
    end
    chk("io throttled", 32'(any), 32'd0);
    tick();
    io_buffer_full = 1'b0;
    #1;
    chk("io write", {mem_wr, 7'b0, mem_a[23:0]}, {1'b1, 7'b0, 24'h030000});
    chk("io dout", {24'b0, mem_dout}, 32'hA5);
    tick();
    chk("io done", {31'b0, ls_done}, 32'h1);
    chk("io single write", 32'(wr_cnt - w0), 32'd1);
    ls_req = 1'b0;
    tick();

    // rollback in c3 of a fetch
    fch_req = 1'b1; fch_addr = 32'h100;
    tick(); tick(); tick();
    rollback_sign_from_rob = 1'b1; fch_req = 1'b0;
    tick();
    rollback_sign_from_rob = 1'b0;
    chk("rb idle mem_a", mem_a, 32'h0);
    any = 0;
    for (int i = 0; i < 6; i++) begin
      if (fch_done) any = 1;
      tick();
    end
    chk("rb no fch_done", 32'(any), 32'd0);

    // rollback during a store word is ignored
    w0 = wr_cnt; lc = 0;
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h310; ls_wdata = 32'h11223344;
    for (int c = 1; c <= 20; c++) begin
      tick();
      rollback_sign_from_rob = (c == 2);
      if (ls_done && lc == 0) begin lc = c; ls_req = 1'b0; end
    end
    rollback_sign_from_rob = 1'b0;
    chk("rb store done cycle", 32'(lc), 32'd5);
    chk("rb store writes", 32'(wr_cnt - w0), 32'd4);
    do_load(32'h310, 2'd2, d, lc);
    chk("rb store readback", d, 32'h11223344);
    chk("load word done cycle", 32'(lc), 32'd6);
    do_load(32'h30000, 2'd0, d, lc);
    chk("byte load data", d, 32'h000000A5);
    chk("byte load done cycle", 32'(lc), 32'd3);

    // rdy low for 2 cycles mid-load of 0x304 (BEEF written earlier, 0x306/7 from ROM)
    w0 = wr_cnt; lc = 0; d = '0;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h304;
    for (int c = 1; c <= 30; c++) begin
      tick();
      rdy = !(c == 3 || c == 4);
      if (ls_done && lc == 0 && rdy) begin lc = c; d = ls_rdata; ls_req = 1'b0; end
    end
    rdy = 1'b1;
    chk("stall load data", d, 32'h1817BEEF);
    chk("stall load no writes", 32'(wr_cnt - w0), 32'd0);

    // store word with a rdy stall, then reset mid-store
    w0 = wr_cnt;
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h320; ls_wdata = 32'h55667788;
    tick();
    tick();
    rdy = 1'b0;
    #1;
    chk("rdy low mem_wr", {31'b0, mem_wr}, 32'h0);
    tick();
    rdy = 1'b1;
    tick();
    rst = 1'b1; ls_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst mem_wr dout", {23'b0, mem_wr, mem_dout}, 32'h0);
    chk("rst data", fch_data | ls_rdata, 32'h0);
    any = 0;
    for (int i = 0; i < 6; i++) begin
      if (ls_done || fch_done || mem_wr) any = 1;
      tick();
    end
    chk("rst no done", 32'(any), 32'd0);
    chk("rst store writes", 32'(wr_cnt - w0), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
